pwl_interp: RTL

- Downstream consumer of the per-segment slope generator in the rgb-lab piecewise-linear (PWL) transfer path.
- Takes the 17 knot values and the 16 segment slopes it produces, and maps a stream of input samples x to PWL outputs y = C[seg] + delta[seg]*off.
- Segments are uniform, 2^SEG_SHIFT wide. Three-stage pipeline with valid/ready on input and output.
- Accepts samples only while the slope table reports cal_valid.

---
 rtl/pwl_interp_if.sv | 25 ++
 rtl/pwl_interp.sv | 104 ++++++++++
 2 files changed

// File: rtl/pwl_interp_if.sv
// Stream interface for pwl_interp: sample input x and interpolated output y, each with
// valid/ready. The slave modport is the interpolator side.
`timescale 1ns/1ps

interface pwl_interp_if #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned XSIZE = 8
);
    logic [XSIZE-1:0] x_in;
    logic             x_valid;
    logic             x_ready;
    logic [DSIZE-1:0] y_out;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output x_in, x_valid, y_ready,
        input  x_ready, y_out, y_valid
    );

    modport slave (
        input  x_in, x_valid, y_ready,
        output x_ready, y_out, y_valid
    );
endinterface

// File: rtl/pwl_interp.sv
// Piecewise-linear interpolator: y = C[seg] + delta[seg]*off over uniform segments, in a
// three-stage valid/ready pipeline. Define PWL_ROUND_EN for round-half-up instead of truncation.
`timescale 1ns/1ps

module pwl_interp #(
    parameter int unsigned DSIZE     = 16,
    parameter int unsigned DT_I      = 8,
    parameter int unsigned DT_D      = 4,
    parameter int unsigned SEG_SHIFT = 4,
    parameter int unsigned NSEG      = 16,
    parameter int unsigned XSIZE     = $clog2(NSEG) + SEG_SHIFT
) (
    input  logic                            clock,
    input  logic                            rst_n,
    input  logic                            cal_valid,
    input  logic [(NSEG+1)*DSIZE-1:0]       knots,
    input  logic [NSEG*(DT_I+DT_D)-1:0]     deltas,
    pwl_interp_if.slave                     bus
);
    localparam int unsigned DW = DT_I + DT_D;
    localparam int unsigned PW = DW + SEG_SHIFT;
    localparam int unsigned SW = XSIZE - SEG_SHIFT;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                 state_q;
    logic                   s1_valid_q, s2_valid_q, y_valid_q;
    logic [DSIZE-1:0]       s1_c_q, s2_c_q, y_out_q;
    logic [DW-1:0]          s1_delta_q;
    logic [SEG_SHIFT-1:0]   s1_off_q;
    logic [PW-1:0]          s2_prod_q;

    logic [SW-1:0]          seg;
    logic [SEG_SHIFT-1:0]   off;
    logic                   stall, accept, pipe_empty;
    logic [PW-1:0]          prod;
    logic [PW:0]            prod_r;
    logic [PW-DT_D:0]       inc;
    logic [DSIZE:0]         sum;
    logic [DSIZE-1:0]       y_next;

    assign seg        = bus.x_in[XSIZE-1:SEG_SHIFT];
    assign off        = bus.x_in[SEG_SHIFT-1:0];
    assign stall      = y_valid_q & ~bus.y_ready;
    // Combinational on cal_valid so a falling table-valid blocks acceptance immediately.
    assign bus.x_ready = (state_q == StRun) & cal_valid & ~stall;
    assign accept     = bus.x_valid & bus.x_ready;
    assign pipe_empty = ~s1_valid_q & ~s2_valid_q & ~y_valid_q;

    assign prod = PW'(s1_delta_q) * PW'(s1_off_q);

`ifdef PWL_ROUND_EN
    localparam logic [PW:0] RHALF = {{PW{1'b0}}, 1'b1} << (DT_D - 1);
    assign prod_r = {1'b0, s2_prod_q} + RHALF;
`else
    assign prod_r = {1'b0, s2_prod_q};
`endif

    assign inc    = prod_r[PW:DT_D];
    assign sum    = {1'b0, s2_c_q} + (DSIZE+1)'(inc);
    assign y_next = sum[DSIZE] ? {DSIZE{1'b1}} : sum[DSIZE-1:0];

    // Control path: FSM, stage valids and the registered output.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_valid_q  <= 1'b0;
            y_out_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle:  if (cal_valid) state_q <= StRun;
                StRun:   if (!cal_valid) state_q <= pipe_empty ? StIdle : StDrain;
                StDrain: if (pipe_empty) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (!stall) begin
                s1_valid_q <= accept;
                s2_valid_q <= s1_valid_q;
                y_valid_q  <= s2_valid_q;
                if (s2_valid_q) y_out_q <= y_next;
            end
        end
    end

    // Datapath: tables are sampled once at S1 so in-flight samples survive table changes.
    always_ff @(posedge clock) begin
        if (!stall) begin
            if (accept) begin
                s1_c_q     <= knots[int'(seg)*DSIZE +: DSIZE];
                s1_delta_q <= deltas[int'(seg)*DW +: DW];
                s1_off_q   <= off;
            end
            if (s1_valid_q) begin
                s2_c_q    <= s1_c_q;
                s2_prod_q <= prod;
            end
        end
    end

    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
endmodule
